ucie_ctl_sb_pkt_serializer: RTL and testbench

//  Parametrised sideband packet builder/serializer for the UCIe controller TX sideband path.
//  - Accepts message requests (opcode/msgcode/subcode/info plus optional 64-bit data) through a

---
 rtl/ucie_ctl_sb_pkt_serializer.sv | 177 +++++++++++++++++
 tb/tb_ucie_ctl_sb_pkt_serializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_pkt_serializer.sv
`timescale 1ns/1ps
// ucie_ctl_sb_pkt_serializer
//   TX sideband packet builder/serializer. Requests are captured with their
//   header (srcid/dstid, control parity, data parity) already built, queued in
//   a small FIFO, then streamed as PHASE_W-bit beats: header first, then the
//   optional 64-bit payload.
//
// Ports
//   i_clk, i_rst              clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   request handshake (ready = FIFO not full)
//   i_opcode/i_msgcode/i_subcode/i_msginfo   header fields
//   i_has_data, i_data        optional 64-bit payload
//   o_phase_valid/i_phase_ready/o_phase/o_phase_last   beat stream
//   o_busy                    FSM active or FIFO occupied
//   o_fifo_count              occupied FIFO entries
module ucie_ctl_sb_pkt_serializer #(
  parameter int         PHASE_W    = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] SRCID      = 3'b001,
  parameter logic [2:0] DSTID      = 3'b101
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_req_valid,
  output logic                              o_req_ready,
  input  logic [4:0]                        i_opcode,
  input  logic [7:0]                        i_msgcode,
  input  logic [7:0]                        i_subcode,
  input  logic [15:0]                       i_msginfo,
  input  logic                              i_has_data,
  input  logic [63:0]                       i_data,
  output logic                              o_phase_valid,
  input  logic                              i_phase_ready,
  output logic [PHASE_W-1:0]                o_phase,
  output logic                              o_phase_last,
  output logic                              o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);

  localparam int NB    = 64 / PHASE_W;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic        has_data;
    logic [63:0] data;
    logic [63:0] hdr;
  } entry_t;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  // Header with CP over bits [61:0] and DP supplied by the caller.
  function automatic logic [63:0] build_hdr(input logic [4:0]  opcode,
                                            input logic [7:0]  msgcode,
                                            input logic [7:0]  subcode,
                                            input logic [15:0] msginfo,
                                            input logic        dp);
    logic [63:0] h;
    h[31:0]  = {SRCID, 7'b0, msgcode, 9'b0, opcode};
    h[63:32] = {1'b0, 1'b0, 3'b0, DSTID, msginfo, subcode};
    h[62]    = ^h[61:0];
    h[63]    = dp;
    return h;
  endfunction

  // ---- request capture: header and parity built before the FIFO ----
  entry_t            wr_entry;
  entry_t            rd_entry;
  entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop, empty;

  always_comb begin
    wr_entry.has_data = i_has_data;
    wr_entry.data     = i_has_data ? i_data : 64'h0;
    wr_entry.hdr      = build_hdr(i_opcode, i_msgcode, i_subcode, i_msginfo,
                                  i_has_data & (^i_data));
  end

  assign o_req_ready = (count != FULL_CNT);
  assign push        = i_req_valid && o_req_ready;
  assign empty       = (count == '0);
  assign rd_entry    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // ---- serializer: FIFO entry -> 128-bit shift register -> beats ----
  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [127:0]       sr, sr_nxt;
  logic               hd, hd_nxt;
  logic               beat_acc;

  assign o_phase_valid = (state != IDLE);
  assign beat_acc      = o_phase_valid && i_phase_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      hd    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      hd    <= hd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    hd_nxt    = hd;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          sr_nxt    = {rd_entry.data, rd_entry.hdr};
          hd_nxt    = rd_entry.has_data;
          cnt_nxt   = '0;
          state_nxt = HDR;
        end
      end
      HDR, DATA: begin
        if (beat_acc) begin
          sr_nxt = sr >> PHASE_W;
          if (cnt == LAST_BEAT) begin
            cnt_nxt = '0;
            if (state == HDR && hd) begin
              // payload already sits in the low bits after the header shifts
              state_nxt = DATA;
            end else if (!empty) begin
              // next packet loads directly so beats continue without a bubble
              pop       = 1'b1;
              sr_nxt    = {rd_entry.data, rd_entry.hdr};
              hd_nxt    = rd_entry.has_data;
              state_nxt = HDR;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_phase      = sr[PHASE_W-1:0];
  assign o_phase_last = (cnt == LAST_BEAT) &&
                        ((state == DATA) || (state == HDR && !hd));
  assign o_busy       = (state != IDLE) || !empty;
  assign o_fifo_count = count;

endmodule

// File: tb/tb_ucie_ctl_sb_pkt_serializer.sv
`timescale 1ns/1ps
// Self-checking bench for ucie_ctl_sb_pkt_serializer: a 32-bit-beat instance
// for the main scenarios and a 16-bit-beat instance for the narrow layout.
module tb_ucie_ctl_sb_pkt_serializer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  opcode = '0;
  logic [7:0]  msgcode = '0, subcode = '0;
  logic [15:0] msginfo = '0;
  logic        has_data = 1'b0;
  logic [63:0] data = '0;
  logic        phase_valid, phase_ready, phase_last, busy;
  logic [31:0] phase;
  logic [2:0]  fifo_count;

  logic dir_ready = 1'b0, rand_mode = 1'b0, rand_rdy = 1'b0;
  assign phase_ready = rand_mode ? rand_rdy : dir_ready;
  always @(negedge clk) rand_rdy = ($urandom_range(0, 2) != 0);

  ucie_ctl_sb_pkt_serializer #(.PHASE_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_opcode(opcode), .i_msgcode(msgcode), .i_subcode(subcode), .i_msginfo(msginfo),
    .i_has_data(has_data), .i_data(data),
    .o_phase_valid(phase_valid), .i_phase_ready(phase_ready),
    .o_phase(phase), .o_phase_last(phase_last),
    .o_busy(busy), .o_fifo_count(fifo_count)
  );

  // 16-bit instance
  logic        b_valid = 1'b0;
  logic        b_req_ready;
  logic [4:0]  b_opcode = '0;
  logic [7:0]  b_msgcode = '0;
  logic        b_phase_valid, b_phase_last, b_busy;
  logic        b_ready = 1'b1;
  logic [15:0] b_phase;
  logic [2:0]  b_count;

  ucie_ctl_sb_pkt_serializer #(.PHASE_W(16), .FIFO_DEPTH(DEPTH)) dut16 (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_valid(b_valid), .o_req_ready(b_req_ready),
    .i_opcode(b_opcode), .i_msgcode(b_msgcode), .i_subcode(8'h00), .i_msginfo(16'h0000),
    .i_has_data(1'b0), .i_data(64'h0),
    .o_phase_valid(b_phase_valid), .i_phase_ready(b_ready),
    .o_phase(b_phase), .o_phase_last(b_phase_last),
    .o_busy(b_busy), .o_fifo_count(b_count)
  );

  typedef struct packed { logic last; logic [31:0] beat; } exp32_t;
  typedef struct packed { logic last; logic [15:0] beat; } exp16_t;
  exp32_t q32[$];
  exp16_t q16[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent packet image {payload, header} built from the field layout.
  function automatic logic [127:0] model(input logic [4:0] op, input logic [7:0] mc,
                                         input logic [7:0] sc, input logic [15:0] mi,
                                         input logic hdv, input logic [63:0] d);
    logic [63:0] h;
    logic [63:0] dd;
    dd       = hdv ? d : 64'h0;
    h[31:0]  = {3'b001, 7'b0, mc, 9'b0, op};
    h[61:32] = {3'b000, 3'b101, mi, sc};
    h[62]    = ^h[61:0];
    h[63]    = ^dd;
    return {dd, h};
  endfunction

  task automatic send(input logic [4:0] op, input logic [7:0] mc, input logic [7:0] sc,
                      input logic [15:0] mi, input logic hdv, input logic [63:0] d,
                      input logic [127:0] img);
    int t = 0;
    int nbeats;
    @(negedge clk);
    opcode = op; msgcode = mc; subcode = sc; msginfo = mi; has_data = hdv; data = d;
    req_valid = 1'b1;
    while (!req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("req_timeout", {63'b0, req_ready}, 64'd1);
    end else begin
      nbeats = hdv ? 4 : 2;
      for (int i = 0; i < nbeats; i++)
        q32.push_back('{last: (i == nbeats - 1), beat: img[i*32 +: 32]});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q32.size() != 0 || q16.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 64'(q32.size() + q16.size()), 64'd0);
  endtask

  // Scoreboard monitors: compare each accepted beat against the queue head.
  always @(negedge clk) begin
    exp32_t e;
    #1;
    if (rst_n) begin
      if (rand_mode) check("count_bound", {63'b0, (fifo_count <= 3'(DEPTH))}, 64'd1);
      if (phase_valid && phase_ready) begin
        if (q32.size() == 0) begin
          check("unexpected_beat32", {32'b0, phase}, 64'hDEAD);
        end else begin
          e = q32.pop_front();
          check("beat32", {32'b0, phase}, {32'b0, e.beat});
          check("last32", {63'b0, phase_last}, {63'b0, e.last});
        end
      end
    end
  end

  always @(negedge clk) begin
    exp16_t e;
    #1;
    if (rst_n && b_phase_valid && b_ready) begin
      if (q16.size() == 0) begin
        check("unexpected_beat16", {48'b0, b_phase}, 64'hDEAD);
      end else begin
        e = q16.pop_front();
        check("beat16", {48'b0, b_phase}, {48'b0, e.beat});
        check("last16", {63'b0, b_phase_last}, {63'b0, e.last});
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] T1_IMG = {64'h0, 32'h0500_0000, 32'h2000_4012};
  localparam logic [127:0] T2_IMG = {32'h0000_0000, 32'h0000_0001, 32'hC500_0000, 32'h2000_001B};

  initial begin
    logic [31:0] held;
    int t;
    // reset values
    #12;
    check("rst_req_ready", {63'b0, req_ready}, 64'd1);
    check("rst_valid", {63'b0, phase_valid}, 64'd0);
    check("rst_phase", {32'b0, phase}, 64'd0);
    check("rst_last", {63'b0, phase_last}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_count", {61'b0, fifo_count}, 64'd0);
    check("rst16_busy", {62'b0, b_busy, b_req_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;

    // T1: header-only packet, with first-beat latency
    dir_ready = 1'b1;
    send(5'h12, 8'h01, 8'h00, 16'h0000, 1'b0, 64'h0, T1_IMG);
    @(negedge clk); #2;
    check("t1_lat_idle", {63'b0, phase_valid}, 64'd0);
    check("t1_busy", {63'b0, busy}, 64'd1);
    @(negedge clk); #2;
    check("t1_lat_valid", {63'b0, phase_valid}, 64'd1);
    drain();

    // T2: packet with payload, CP=1 and DP=1
    send(5'h1B, 8'h00, 8'h00, 16'h0000, 1'b1, 64'h1, T2_IMG);
    drain();

    // T3: fill under backpressure, then stream with no gaps
    dir_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(5'h12, 8'h01, 8'h00, 16'h0000, 1'b0, 64'h0, T1_IMG);
    @(negedge clk); #2;
    check("t3_full_ready", {63'b0, req_ready}, 64'd0);
    check("t3_full_count", {61'b0, fifo_count}, 64'd4);
    held = phase;
    check("t3_hold_first", {32'b0, held}, 64'h2000_4012);
    repeat (3) @(negedge clk);
    #2;
    check("t3_hold_stable", {32'b0, phase}, {32'b0, held});
    check("t3_hold_last", {63'b0, phase_last}, 64'd0);
    @(negedge clk);
    dir_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2 check("t3_no_gap", {63'b0, phase_valid}, 64'd1);
      @(negedge clk);
    end
    drain();

    // T4: 16-bit beats
    @(negedge clk);
    b_opcode = 5'h12; b_msgcode = 8'h01; b_valid = 1'b1;
    q16.push_back('{last: 1'b0, beat: 16'h4012});
    q16.push_back('{last: 1'b0, beat: 16'h2000});
    q16.push_back('{last: 1'b0, beat: 16'h0000});
    q16.push_back('{last: 1'b1, beat: 16'h0500});
    @(posedge clk);
    #1 b_valid = 1'b0;
    drain();

    // T5: reset in the middle of a payload packet
    send(5'h1B, 8'h00, 8'h00, 16'h0000, 1'b1, 64'h1, T2_IMG);
    t = 0;
    while (!phase_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_valid", {63'b0, phase_valid}, 64'd0);
    check("t5_count", {61'b0, fifo_count}, 64'd0);
    check("t5_req_ready", {63'b0, req_ready}, 64'd1);
    check("t5_busy", {63'b0, busy}, 64'd0);
    q32.delete();
    @(negedge clk) rst_n = 1'b1;
    send(5'h12, 8'h01, 8'h00, 16'h0000, 1'b0, 64'h0, T1_IMG);
    drain();

    // T6: random traffic and backpressure
    rand_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [4:0]  op;
      logic [7:0]  mc, sc;
      logic [15:0] mi;
      logic        hdv;
      logic [63:0] d;
      op  = 5'($urandom);
      mc  = 8'($urandom);
      sc  = 8'($urandom);
      mi  = 16'($urandom);
      hdv = 1'($urandom);
      d   = {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(op, mc, sc, mi, hdv, d, model(op, mc, sc, mi, hdv, d));
    end
    drain();
    rand_mode = 1'b0;
    @(negedge clk); #2;
    check("end_idle", {63'b0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
